// File: rtl/ks_pkg.sv
// ============================================================================
// ks_pkg : shared widths, types and prefix-network indexing for ks_32b
// Rev 1.0
// ============================================================================
`default_nettype none

package ks_pkg;

  localparam int KS_WIDTH  = 32;
  localparam int KS_LEVELS = $clog2(KS_WIDTH);

  typedef logic [KS_WIDTH-1:0] ks_operand_t;
  typedef logic [KS_WIDTH:0]   ks_result_t;

  // Propagate terms are stored only where a later level consumes them:
  // level lvl (1..KS_LEVELS-1) keeps bits [KS_WIDTH-1 : 2**lvl].
  function automatic int ks_p_base(int lvl);
    int base;
    base = 0;
    for (int j = 1; j < lvl; j++) begin
      base += KS_WIDTH - (1 << j);
    end
    return base;
  endfunction

  function automatic int ks_p_idx(int lvl, int bit_pos);
    return ks_p_base(lvl) + bit_pos - (1 << lvl);
  endfunction

  localparam int KS_P_BITS = ks_p_base(KS_LEVELS);

endpackage

`default_nettype wire

// File: rtl/ks_prefix_cell.sv
// ============================================================================
// ks_prefix_cell      : black cell, (G,P) o (G,P)
// ks_prefix_cell_gray : gray variant, group generate only
// Rev 1.0
// ============================================================================
`default_nettype none

module ks_prefix_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule

module ks_prefix_cell_gray (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  output logic g_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);

endmodule

`default_nettype wire

// File: rtl/ks_32b.sv
// ============================================================================
// ks_32b : 32-bit unsigned Kogge-Stone adder, registered 33-bit sum
// Rev 1.0
// ============================================================================
`default_nettype none

module ks_32b
  import ks_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KS_WIDTH-1:0] in0,
  input  logic [KS_WIDTH-1:0] in1,
  output logic [KS_WIDTH:0]   out0
);

  ks_operand_t          w_gen;
  ks_operand_t          w_prop;
  ks_operand_t          w_carry;
  ks_operand_t          w_glvl [0:KS_LEVELS];
  logic [KS_P_BITS-1:0] w_pflat;
  ks_result_t           out0_d;
  ks_result_t           out0_q;

  assign w_gen     = in0 & in1;
  assign w_prop    = in0 ^ in1;
  assign w_glvl[0] = w_gen;

  for (genvar k = 0; k < KS_LEVELS; k++) begin : g_level
    localparam int SPAN = 1 << k;
    logic [KS_WIDTH-1:SPAN] w_pin;

    if (k == 0) begin : g_pin_pre
      assign w_pin = w_prop[KS_WIDTH-1:1];
    end else begin : g_pin_net
      for (genvar i = SPAN; i < KS_WIDTH; i++) begin : g_bit
        assign w_pin[i] = w_pflat[ks_p_idx(k, i)];
      end
    end

    // Bits below 2*SPAN already span down to bit 0, so their P is dead: gray cells.
    for (genvar i = 0; i < KS_WIDTH; i++) begin : g_bit
      if (i < SPAN) begin : g_pass
        assign w_glvl[k+1][i] = w_glvl[k][i];
      end else if (i < 2 * SPAN) begin : g_gray
        ks_prefix_cell_gray u_cell (
          .g_hi_i (w_glvl[k][i]),
          .p_hi_i (w_pin[i]),
          .g_lo_i (w_glvl[k][i-SPAN]),
          .g_o    (w_glvl[k+1][i])
        );
      end else begin : g_black
        ks_prefix_cell u_cell (
          .g_hi_i (w_glvl[k][i]),
          .p_hi_i (w_pin[i]),
          .g_lo_i (w_glvl[k][i-SPAN]),
          .p_lo_i (w_pin[i-SPAN]),
          .g_o    (w_glvl[k+1][i]),
          .p_o    (w_pflat[ks_p_idx(k+1, i)])
        );
      end
    end
  end

  assign w_carry = {w_glvl[KS_LEVELS][KS_WIDTH-2:0], 1'b0};
  assign out0_d  = {w_glvl[KS_LEVELS][KS_WIDTH-1], w_prop ^ w_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
    end else begin
      out0_q <= out0_d;
    end
  end

  assign out0 = out0_q;

endmodule

`default_nettype wire

// File: tb/tb_ks_32b.sv
// ============================================================================
// tb_ks_32b : directed and random self-checking bench for ks_32b
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ks_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [32:0] out0;

  int n_checks = 0;
  int n_errors = 0;

  ks_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in0   (in0),
    .in1   (in1),
    .out0  (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [32:0] exp);
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
    check(tag, out0, exp);
  endtask

  logic [31:0] dir_a   [15];
  logic [31:0] dir_b   [15];
  logic [32:0] dir_exp [15];

  initial begin
    dir_a[0]  = 32'hFFFF_FFFF; dir_b[0]  = 32'h0000_0001; dir_exp[0]  = 33'h1_0000_0000;
    dir_a[1]  = 32'hFFFF_FFFF; dir_b[1]  = 32'hFFFF_FFFF; dir_exp[1]  = 33'h1_FFFF_FFFE;
    dir_a[2]  = 32'hAAAA_AAAA; dir_b[2]  = 32'h5555_5555; dir_exp[2]  = 33'h0_FFFF_FFFF;
    dir_a[3]  = 32'h0000_0000; dir_b[3]  = 32'h0000_0000; dir_exp[3]  = 33'h0_0000_0000;
    dir_a[4]  = 32'h8000_0000; dir_b[4]  = 32'h8000_0000; dir_exp[4]  = 33'h1_0000_0000;
    dir_a[5]  = 32'h1234_5678; dir_b[5]  = 32'h8765_4321; dir_exp[5]  = 33'h0_9999_9999;
    dir_a[6]  = 32'h0000_0001; dir_b[6]  = 32'hFFFF_FFFE; dir_exp[6]  = 33'h0_FFFF_FFFF;
    dir_a[7]  = 32'hDEAD_BEEF; dir_b[7]  = 32'h0000_0001; dir_exp[7]  = 33'h0_DEAD_BEF0;
    dir_a[8]  = 32'h7FFF_FFFF; dir_b[8]  = 32'h0000_0001; dir_exp[8]  = 33'h0_8000_0000;
    dir_a[9]  = 32'hFFFF_0000; dir_b[9]  = 32'h0001_0000; dir_exp[9]  = 33'h1_0000_0000;
    dir_a[10] = 32'h0000_FFFF; dir_b[10] = 32'h0000_FFFF; dir_exp[10] = 33'h0_0001_FFFE;
    dir_a[11] = 32'hCAFE_BABE; dir_b[11] = 32'h1111_1111; dir_exp[11] = 33'h0_DC0F_CBCF;
    dir_a[12] = 32'hF0F0_F0F0; dir_b[12] = 32'h0F0F_0F0F; dir_exp[12] = 33'h0_FFFF_FFFF;
    dir_a[13] = 32'h8000_0001; dir_b[13] = 32'h8000_0001; dir_exp[13] = 33'h1_0000_0002;
    dir_a[14] = 32'h1357_9BDF; dir_b[14] = 32'h0246_8ACE; dir_exp[14] = 33'h0_159E_26AD;
  end

  logic [31:0] span_a   [5];
  logic [32:0] span_exp [5];

  initial begin
    span_a[0] = 32'h0000_0001; span_exp[0] = 33'h0_0000_0002;
    span_a[1] = 32'h0000_0003; span_exp[1] = 33'h0_0000_0004;
    span_a[2] = 32'h0000_000F; span_exp[2] = 33'h0_0000_0010;
    span_a[3] = 32'h0000_00FF; span_exp[3] = 33'h0_0000_0100;
    span_a[4] = 32'h0000_FFFF; span_exp[4] = 33'h0_0001_0000;
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0;
    in0   = 32'hFFFF_FFFF;
    in1   = 32'h0000_0001;
    #1;
    check("reset_async", out0, 33'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", c), out0, 33'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", out0, 33'h1_0000_0000);

    // Directed table, applied back to back: each sum lands one cycle later.
    for (int j = 0; j < 15; j++) begin
      step($sformatf("dir%0d", j), dir_a[j], dir_b[j], dir_exp[j]);
    end

    for (int s = 0; s < 5; s++) begin
      step($sformatf("span%0d", 1 << s), span_a[s], 32'h1, span_exp[s]);
    end

    // Mid-stream reset: clears between edges, holds through edges.
    step("pre_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", out0, 33'h0);
    @(posedge clk);
    #1;
    check("mid_reset_hold", out0, 33'h0);
    rst_n = 1'b1;
    step("post_reset", 32'h0000_00FF, 32'h0000_0001, 33'h0_0000_0100);

    for (int r = 0; r < 3000; r++) begin
      ra = $urandom;
      rb = $urandom;
      case (r % 4)
        1: begin ra = ~(32'h1 << $urandom_range(31, 0)); rb = $urandom_range(255, 1); end
        2: begin ra = 32'h1 << $urandom_range(31, 0); rb = 32'h1 << $urandom_range(31, 0); end
        3: begin ra = ra | 32'hFFFF_F000; rb = ~ra + 32'($urandom_range(2, 0)); end
        default: ;
      endcase
      step($sformatf("rand%0d", r), ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
